instruction_fetch: RTL and testbench

Front pipeline stage of the MIPS core: owns the program counter and the instruction memory, and drives the IF/ID pipeline register consumed by `instruction_decoder`. It fetches one instruction per cycle and follows the decoder's stall and branch requests, with a one-instruction branch delay slot. It also accepts program loading from the debug unit.

---
 rtl/mips_pkg.sv | 13 +
 rtl/instruction_fetch_if.sv | 32 +++
 rtl/instruction_memory.sv | 24 ++
 rtl/instruction_fetch.sv | 65 ++++++
 tb/tb_instruction_fetch.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and default widths shared by the MIPS pipeline stages
//   INSTR_W / ADDR_W / IMEM_ADDR_W : default instruction, byte-address and imem word-address widths
//   HALT_OPCODE : opcode that stops the core when HALT_DETECT_EN is defined
//   NOP_INSTR   : bubble word driven into IF/ID
//   PC_INC      : sequential PC step in bytes
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam int IMEM_ADDR_W = 10;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam int PC_INC = 4;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundle between the fetch stage and its neighbours
//   inputs to fetch : i_enable (debug advance), i_stall/i_branch/i_branch_addr (decoder),
//                     i_wr_en/i_wr_addr/i_wr_data (program load)
//   outputs of fetch: o_instruction/o_pc (IF/ID register), o_pc_current, o_halt (debug)
//   slave = fetch stage side, master = environment side
interface instruction_fetch_if
  import mips_pkg::*;
#(
  parameter int NB_INSTRUCTIONS = INSTR_W,
  parameter int NB_ADDRESS = ADDR_W,
  parameter int NB_IMEM_ADDR = IMEM_ADDR_W
);
  logic i_enable;
  logic i_stall;
  logic i_branch;
  logic [NB_ADDRESS-1:0] i_branch_addr;
  logic i_wr_en;
  logic [NB_IMEM_ADDR-1:0] i_wr_addr;
  logic [NB_INSTRUCTIONS-1:0] i_wr_data;
  logic [NB_INSTRUCTIONS-1:0] o_instruction;
  logic [NB_ADDRESS-1:0] o_pc;
  logic [NB_ADDRESS-1:0] o_pc_current;
  logic o_halt;
  modport slave (
    input i_enable, i_stall, i_branch, i_branch_addr, i_wr_en, i_wr_addr, i_wr_data,
    output o_instruction, o_pc, o_pc_current, o_halt
  );
  modport master (
    output i_enable, i_stall, i_branch, i_branch_addr, i_wr_en, i_wr_addr, i_wr_data,
    input o_instruction, o_pc, o_pc_current, o_halt
  );
endinterface

// File: rtl/instruction_memory.sv
// instruction_memory: 2^NB_ADDR x NB_DATA RAM, one write port, one registered read port
//   i_clk, i_wr_en/i_wr_addr/i_wr_data : write port
//   i_rd_en/i_rd_addr -> o_rd_data      : read port, output updates only when i_rd_en
//   a same-edge write and read of one word returns the old word
module instruction_memory
  import mips_pkg::*;
#(
  parameter int NB_DATA = INSTR_W,
  parameter int NB_ADDR = IMEM_ADDR_W
) (
  input  logic i_clk,
  input  logic i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic i_rd_en,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);
  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage - PC, instruction memory and IF/ID register
//   i_clk, i_reset (sync, active-high)
//   bus (instruction_fetch_if.slave): debug enable, decoder stall/branch, program load,
//   IF/ID instruction + PC+4, live PC, sticky halt
//   HALT_DETECT_EN: when defined, fetching opcode 6'b111111 halts the stage
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int NB_INSTRUCTIONS = INSTR_W,
  parameter int NB_ADDRESS = ADDR_W,
  parameter int NB_IMEM_ADDR = IMEM_ADDR_W
) (
  input logic i_clk,
  input logic i_reset,
  instruction_fetch_if.slave bus
);
  logic [NB_ADDRESS-1:0] pc, pc_inc, ifid_pc;
  logic [NB_INSTRUCTIONS-1:0] rd_data;
  logic out_nop, halted, advance;
  assign pc_inc = pc + NB_ADDRESS'(PC_INC);
  assign advance = bus.i_enable & ~halted & ~bus.i_stall;
  instruction_memory #(
    .NB_DATA(NB_INSTRUCTIONS),
    .NB_ADDR(NB_IMEM_ADDR)
  ) u_imem (
    .i_clk(i_clk),
    .i_wr_en(bus.i_wr_en),
    .i_wr_addr(bus.i_wr_addr),
    .i_wr_data(bus.i_wr_data),
    .i_rd_en(advance),
    .i_rd_addr(pc[NB_IMEM_ADDR+1:2]),
    .o_rd_data(rd_data)
  );
  // The RAM output register doubles as the IF/ID instruction; out_nop masks it
  // with a NOP after reset and once halted, since RAM contents are never cleared.
  always_ff @(posedge i_clk)
    if (i_reset) begin
      pc <= '0;
      ifid_pc <= '0;
      out_nop <= 1'b1;
    end else if (bus.i_enable) begin
      if (halted) out_nop <= 1'b1;
      else if (!bus.i_stall) begin
        pc <= bus.i_branch ? (bus.i_branch_addr & ~NB_ADDRESS'(3)) : pc_inc;
        ifid_pc <= pc_inc;
        out_nop <= 1'b0;
      end
    end
`ifdef HALT_DETECT_EN
  // The halt word is only visible after the edge that reads it, so halt is
  // raised combinationally from IF/ID and then latched; the held PC is
  // recovered as the halt word's own address (IF/ID PC+4 minus 4).
  logic halt_q;
  always_ff @(posedge i_clk)
    if (i_reset) halt_q <= 1'b0;
    else if (bus.i_enable && halted) halt_q <= 1'b1;
  assign halted = halt_q | (~out_nop & (rd_data[NB_INSTRUCTIONS-1 -: 6] == HALT_OPCODE));
`else
  assign halted = 1'b0;
`endif
  assign bus.o_instruction = out_nop ? NB_INSTRUCTIONS'(NOP_INSTR) : rd_data;
  assign bus.o_pc = ifid_pc;
  assign bus.o_pc_current = halted ? ifid_pc - NB_ADDRESS'(PC_INC) : pc;
  assign bus.o_halt = halted;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import mips_pkg::*;
`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  instruction_fetch_if bus();
  instruction_fetch dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  logic [31:0] mmem [1024];
  logic [31:0] m_pc, m_ins, m_opc;
  logic m_halt;
  logic [31:0] seqw [4];
  int n_checks = 0;
  int n_fail = 0;
  function automatic logic [96:0] got();
    return {bus.o_instruction, bus.o_pc, bus.o_pc_current, bus.o_halt};
  endfunction
  function automatic logic [96:0] want();
    return {m_ins, m_opc, m_pc, m_halt};
  endfunction
  function automatic logic [31:0] no_halt();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31] = 1'b0;
    return w;
  endfunction
  task automatic idle();
    bus.i_enable = 1'b1;
    bus.i_stall = 1'b0;
    bus.i_branch = 1'b0;
    bus.i_branch_addr = '0;
    bus.i_wr_en = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
  endtask
  task automatic tick();
    logic [31:0] w;
    if (rst) begin
      m_pc = 0; m_ins = 0; m_opc = 0; m_halt = 0;
    end else if (bus.i_enable) begin
      if (m_halt) m_ins = 0;
      else if (!bus.i_stall) begin
        w = mmem[m_pc[11:2]];
        m_ins = w;
        m_opc = m_pc + 4;
        if (HALT_EN && w[31:26] == 6'h3f) m_halt = 1'b1;
        else m_pc = bus.i_branch ? {bus.i_branch_addr[31:2], 2'b00} : m_pc + 4;
      end
    end
    if (bus.i_wr_en) mmem[bus.i_wr_addr] = bus.i_wr_data;
    @(posedge clk);
    #1;
  endtask
  task automatic restart();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    seqw = '{32'h2001_0001, 32'h2002_0002, 32'h0022_1820, 32'hAC03_0010};
    idle();
    rst = 1'b1;
    bus.i_wr_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.i_wr_addr = 10'(i);
      bus.i_wr_data = (i < 4) ? seqw[i] : no_halt();
      tick();
    end
    bus.i_wr_en = 1'b0;
    tick();
    n_checks++;
    if (got() !== 97'h0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", got(), 97'h0);
    end
  endtask
  task automatic test_sequential();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (bus.o_instruction !== seqw[k-1] || bus.o_pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL seq edge %0d: got ins=%h pc=%h want ins=%h pc=%h", k, bus.o_instruction, bus.o_pc, seqw[k-1], 32'(4 * k));
      end
      n_checks++;
      if (got() !== want()) begin
        n_fail++;
        $display("FAIL seq model %0d: got %h want %h", k, got(), want());
      end
    end
  endtask
  task automatic test_branch();
    restart();
    tick();
    tick();
    bus.i_branch = 1'b1;
    bus.i_branch_addr = 32'h0000_0043;
    tick();
    bus.i_branch = 1'b0;
    n_checks++;
    if (bus.o_instruction !== seqw[2]) begin
      n_fail++;
      $display("FAIL branch delay slot: got %h want %h", bus.o_instruction, seqw[2]);
    end
    tick();
    n_checks++;
    if (bus.o_instruction !== mmem[16] || bus.o_pc !== 32'h44) begin
      n_fail++;
      $display("FAIL branch target: got ins=%h pc=%h want ins=%h pc=%h", bus.o_instruction, bus.o_pc, mmem[16], 32'h44);
    end
    n_checks++;
    if (got() !== want()) begin
      n_fail++;
      $display("FAIL branch model: got %h want %h", got(), want());
    end
  endtask
  task automatic test_stall();
    restart();
    repeat (3) tick();
    bus.i_stall = 1'b1;
    bus.i_branch = 1'b1;
    bus.i_branch_addr = 32'h80;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (bus.o_instruction !== seqw[2] || bus.o_pc !== 32'd12) begin
        n_fail++;
        $display("FAIL stall hold %0d: got ins=%h pc=%h want ins=%h pc=%h", k, bus.o_instruction, bus.o_pc, seqw[2], 32'd12);
      end
    end
    bus.i_stall = 1'b0;
    bus.i_branch = 1'b0;
    tick();
    n_checks++;
    if (bus.o_instruction !== seqw[3] || bus.o_pc !== 32'd16) begin
      n_fail++;
      $display("FAIL stall release: got ins=%h pc=%h want ins=%h pc=%h", bus.o_instruction, bus.o_pc, seqw[3], 32'd16);
    end
  endtask
  task automatic test_enable();
    logic [31:0] nw;
    nw = no_halt();
    restart();
    tick();
    tick();
    bus.i_enable = 1'b0;
    bus.i_wr_en = 1'b1;
    bus.i_wr_addr = 10'd6;
    bus.i_wr_data = nw;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.i_wr_en = 1'b0;
      n_checks++;
      if (got() !== {seqw[1], 32'd8, 32'd8, 1'b0}) begin
        n_fail++;
        $display("FAIL enable hold %0d: got %h want %h", k, got(), {seqw[1], 32'd8, 32'd8, 1'b0});
      end
    end
    bus.i_enable = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (bus.o_instruction !== nw || bus.o_pc !== 32'd28) begin
      n_fail++;
      $display("FAIL enable load: got ins=%h pc=%h want ins=%h pc=%h", bus.o_instruction, bus.o_pc, nw, 32'd28);
    end
  endtask
  task automatic test_halt();
    idle();
    rst = 1'b1;
    bus.i_wr_en = 1'b1;
    bus.i_wr_addr = 10'd2;
    bus.i_wr_data = 32'hFC00_0000;
    tick();
    bus.i_wr_en = 1'b0;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (got() !== want()) begin
        n_fail++;
        $display("FAIL halt model %0d: got %h want %h", k, got(), want());
      end
`ifdef HALT_DETECT_EN
      n_checks++;
      if (k >= 3 && (bus.o_halt !== 1'b1 || bus.o_pc_current !== 32'h8 ||
          bus.o_instruction !== (k == 3 ? 32'hFC00_0000 : 32'h0))) begin
        n_fail++;
        $display("FAIL halt edge %0d: got halt=%b cur=%h ins=%h", k, bus.o_halt, bus.o_pc_current, bus.o_instruction);
      end
`endif
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.o_halt !== 1'b0 || bus.o_pc_current !== 32'h0) begin
      n_fail++;
      $display("FAIL halt reset: got halt=%b cur=%h want halt=0 cur=0", bus.o_halt, bus.o_pc_current);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.o_instruction !== mmem[0] || got() !== want()) begin
      n_fail++;
      $display("FAIL halt refetch: got %h want %h", got(), want());
    end
  endtask
  task automatic test_random();
    restart();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.i_enable = ($urandom_range(0, 9) != 0);
      bus.i_stall = ($urandom_range(0, 5) == 0);
      bus.i_branch = ($urandom_range(0, 4) == 0);
      bus.i_branch_addr = $urandom;
      bus.i_wr_en = ($urandom_range(0, 3) == 0);
      bus.i_wr_addr = 10'($urandom);
      bus.i_wr_data = ($urandom_range(0, 19) == 0) ? {6'h3f, 26'($urandom)} : no_halt();
      tick();
      n_checks++;
      if (got() !== want()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h want %h", k, got(), want());
      end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_enable();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
